// File: rtl/updown_mod_counter.sv
// Up/down counter over 0..limit with a selectable boundary policy: wrap or saturate.
// The count and the boundary pulses are registered. at_max and at_min are decoded from the count.
module updown_mod_counter #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             wrapped,
  output logic             sat_hit,
  output logic             at_max,
  output logic             at_min
);

  logic [WIDTH-1:0] r_count;
  logic             r_wrapped;
  logic             r_sat_hit;
  logic [WIDTH-1:0] w_next;
  logic             w_wrap;
  logic             w_sat;

  function automatic logic [WIDTH-1:0] clamp_to_limit(input logic [WIDTH-1:0] v,
                                                      input logic [WIDTH-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  always_comb begin
    w_next = r_count;
    w_wrap = 1'b0;
    w_sat  = 1'b0;
    if (clr) begin
      w_next = '0;
    end else if (load) begin
      w_next = clamp_to_limit(load_val, limit);
    end else if (en) begin
      if (dir) begin
        if (r_count < limit) begin
          w_next = r_count + 1'b1;
        end else if (SATURATE) begin
          w_next = limit;
          w_sat  = 1'b1;
        end else begin
          w_next = '0;
          w_wrap = 1'b1;
        end
      end else begin
        if (r_count == '0) begin
          if (SATURATE) begin
            w_sat = 1'b1;
          end else begin
            w_next = limit;
            w_wrap = 1'b1;
          end
        end else if (r_count > limit) begin
          // The limit was lowered under the count, so pull back into range without a flag.
          w_next = limit;
        end else begin
          w_next = r_count - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_count   <= '0;
      r_wrapped <= 1'b0;
      r_sat_hit <= 1'b0;
    end else begin
      r_count   <= w_next;
      r_wrapped <= w_wrap;
      r_sat_hit <= w_sat;
    end
  end

  assign count   = r_count;
  assign wrapped = r_wrapped;
  assign sat_hit = r_sat_hit;
  assign at_max  = (r_count >= limit);
  assign at_min  = (r_count == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: a wrap-mode and a saturate-mode instance share the stimulus.
// Outputs are checked against directed constants and against a reference model computed from the counting rules.
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       nrst, clr, load, en, dir;
  logic [7:0] load_val, limit;
  logic [7:0] cnt_w, cnt_s;
  logic       wrap_w, sat_w, max_w, min_w;
  logic       wrap_s, sat_s, max_s, min_s;

  logic [7:0] m_cnt  [2];
  logic       m_wrap [2];
  logic       m_sat  [2];
  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(8), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .nrst(nrst), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .dir(dir), .limit(limit), .count(cnt_w), .wrapped(wrap_w),
    .sat_hit(sat_w), .at_max(max_w), .at_min(min_w));

  updown_mod_counter #(.WIDTH(8), .SATURATE(1'b1)) u_sat (
    .clk(clk), .nrst(nrst), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .dir(dir), .limit(limit), .count(cnt_s), .wrapped(wrap_s),
    .sat_hit(sat_s), .at_max(max_s), .at_min(min_s));

  // Reference: index 0 is the wrap-mode instance, index 1 the saturate-mode instance.
  task automatic model_tick();
    int c, lim;
    lim = int'(limit);
    for (int m = 0; m < 2; m++) begin
      c = int'(m_cnt[m]);
      m_wrap[m] = 1'b0;
      m_sat[m]  = 1'b0;
      if (clr) c = 0;
      else if (load) c = (int'(load_val) < lim) ? int'(load_val) : lim;
      else if (en && dir) begin
        if (c < lim) c = c + 1;
        else if (m == 1) begin c = lim; m_sat[m] = 1'b1; end
        else begin c = 0; m_wrap[m] = 1'b1; end
      end else if (en) begin
        if (c == 0) begin
          if (m == 1) m_sat[m] = 1'b1;
          else begin c = lim; m_wrap[m] = 1'b1; end
        end else if (c > lim) c = lim;
        else c = c - 1;
      end
      m_cnt[m] = 8'(c);
    end
  endtask

  task automatic step();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clr = 0; load = 0; en = 0; dir = 0; load_val = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    nrst = 1'b0;
    for (int m = 0; m < 2; m++) begin m_cnt[m] = 0; m_wrap[m] = 0; m_sat[m] = 0; end
    @(posedge clk);
    #1;
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    limit = 8'd9;
    do_reset();
    n_chk++;
    if (cnt_w !== 8'd0 || wrap_w !== 1'b0 || sat_w !== 1'b0 || min_w !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_wrap: count=%0d wrapped=%b sat_hit=%b at_min=%b, required 0 0 0 1",
               cnt_w, wrap_w, sat_w, min_w);
    end
    n_chk++;
    if (cnt_s !== 8'd0 || wrap_s !== 1'b0 || sat_s !== 1'b0 || min_s !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_sat: count=%0d wrapped=%b sat_hit=%b at_min=%b, required 0 0 0 1",
               cnt_s, wrap_s, sat_s, min_s);
    end
  endtask

  task automatic test_wrap_up();
    do_reset();
    limit = 8'd9; en = 1; dir = 1;
    for (int k = 1; k <= 12; k++) begin
      step();
      n_chk++;
      if (cnt_w !== 8'(k % 10) || wrap_w !== (k == 10) || max_w !== ((k % 10) == 9)) begin
        n_fail++;
        $display("FAIL wrap_up step %0d: count=%0d wrapped=%b at_max=%b, required %0d %b %b",
                 k, cnt_w, wrap_w, max_w, k % 10, (k == 10), ((k % 10) == 9));
      end
    end
    idle_inputs();
  endtask

  task automatic test_wrap_down();
    int exp_seq [3] = '{9, 8, 7};
    clr = 1; step(); idle_inputs();
    limit = 8'd9; en = 1; dir = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_chk++;
      if (cnt_w !== 8'(exp_seq[k]) || wrap_w !== (k == 0)) begin
        n_fail++;
        $display("FAIL wrap_down step %0d: count=%0d wrapped=%b, required %0d %b",
                 k, cnt_w, wrap_w, exp_seq[k], (k == 0));
      end
    end
    idle_inputs();
  endtask

  task automatic test_saturate();
    limit = 8'd5; load = 1; load_val = 8'd5; step(); idle_inputs();
    en = 1; dir = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_chk++;
      if (cnt_s !== 8'd5 || sat_s !== 1'b1 || wrap_s !== 1'b0) begin
        n_fail++;
        $display("FAIL sat_up cycle %0d: count=%0d sat_hit=%b wrapped=%b, required 5 1 0",
                 k, cnt_s, sat_s, wrap_s);
      end
    end
    idle_inputs(); clr = 1; step(); idle_inputs();
    en = 1; dir = 0;
    for (int k = 0; k < 2; k++) begin
      step();
      n_chk++;
      if (cnt_s !== 8'd0 || sat_s !== 1'b1) begin
        n_fail++;
        $display("FAIL sat_down cycle %0d: count=%0d sat_hit=%b, required 0 1", k, cnt_s, sat_s);
      end
    end
    idle_inputs(); step();
    n_chk++;
    if (sat_s !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_pulse_end: sat_hit=%b, required 0", sat_s);
    end
  endtask

  task automatic test_priority();
    limit = 8'd9; load = 1; load_val = 8'd4; step();
    clr = 1; load = 1; load_val = 8'd8; en = 1; dir = 1; step();
    n_chk++;
    if (cnt_w !== 8'd0 || cnt_s !== 8'd0) begin
      n_fail++;
      $display("FAIL priority_clr: counts=%0d/%0d, required 0", cnt_w, cnt_s);
    end
    idle_inputs(); limit = 8'd50; load = 1; load_val = 8'd200; en = 1; step();
    n_chk++;
    if (cnt_w !== 8'd50 || cnt_s !== 8'd50 || wrap_w !== 1'b0 || sat_s !== 1'b0) begin
      n_fail++;
      $display("FAIL load_clamp: counts=%0d/%0d flags=%b%b, required 50 and no flag",
               cnt_w, cnt_s, wrap_w, sat_s);
    end
    idle_inputs();
  endtask

  task automatic test_limit_lower();
    limit = 8'd100; load = 1; load_val = 8'd40; step(); idle_inputs();
    limit = 8'd20; en = 1; dir = 0; step();
    n_chk++;
    if (cnt_w !== 8'd20 || cnt_s !== 8'd20 || wrap_w || sat_w || wrap_s || sat_s) begin
      n_fail++;
      $display("FAIL lower_down: counts=%0d/%0d flags=%b%b%b%b, required 20 and no flags",
               cnt_w, cnt_s, wrap_w, sat_w, wrap_s, sat_s);
    end
    idle_inputs(); limit = 8'd100; load = 1; load_val = 8'd40; step(); idle_inputs();
    limit = 8'd20; en = 1; dir = 1; step();
    n_chk++;
    if (cnt_w !== 8'd0 || wrap_w !== 1'b1) begin
      n_fail++;
      $display("FAIL lower_up_wrap: count=%0d wrapped=%b, required 0 1", cnt_w, wrap_w);
    end
    n_chk++;
    if (cnt_s !== 8'd20 || sat_s !== 1'b1) begin
      n_fail++;
      $display("FAIL lower_up_sat: count=%0d sat_hit=%b, required 20 1", cnt_s, sat_s);
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    limit = 8'd9; load = 1; load_val = 8'd7; step(); idle_inputs();
    en = 1; dir = 1;
    #3;
    nrst = 1'b0;
    #1;
    n_chk++;
    if (cnt_w !== 8'd0 || cnt_s !== 8'd0 || wrap_w || sat_s) begin
      n_fail++;
      $display("FAIL async_reset: counts=%0d/%0d, required 0 before any edge", cnt_w, cnt_s);
    end
    #2;
    nrst = 1'b1;
    for (int m = 0; m < 2; m++) begin m_cnt[m] = 0; m_wrap[m] = 0; m_sat[m] = 0; end
    step();
    n_chk++;
    if (cnt_w !== 8'd1 || cnt_s !== 8'd1 || wrap_w || sat_s) begin
      n_fail++;
      $display("FAIL restart: counts=%0d/%0d, required 1 with no flag", cnt_w, cnt_s);
    end
    idle_inputs();
  endtask

  task automatic test_limit_zero();
    limit = 8'd0; clr = 1; step(); idle_inputs();
    en = 1;
    for (int k = 0; k < 4; k++) begin
      dir = k[0];
      step();
      n_chk++;
      if (cnt_w !== 8'd0 || cnt_s !== 8'd0 || wrap_w !== 1'b1 || sat_s !== 1'b1 ||
          sat_w !== 1'b0 || wrap_s !== 1'b0) begin
        n_fail++;
        $display("FAIL limit_zero dir=%b: counts=%0d/%0d wrapped=%b sat_hit=%b, required 0 1 1",
                 dir, cnt_w, cnt_s, wrap_w, sat_s);
      end
    end
    idle_inputs();
  endtask

  task automatic test_full_range();
    limit = 8'd255; load = 1; load_val = 8'd254; step(); idle_inputs();
    en = 1; dir = 1; step(); step();
    n_chk++;
    if (cnt_w !== 8'd0 || wrap_w !== 1'b1) begin
      n_fail++;
      $display("FAIL full_up: count=%0d wrapped=%b, required 0 1", cnt_w, wrap_w);
    end
    dir = 0; step();
    n_chk++;
    if (cnt_w !== 8'd255 || wrap_w !== 1'b1) begin
      n_fail++;
      $display("FAIL full_down: count=%0d wrapped=%b, required 255 1", cnt_w, wrap_w);
    end
    idle_inputs();
  endtask

  task automatic test_hold();
    limit = 8'd9; load = 1; load_val = 8'd3; step(); idle_inputs();
    for (int k = 0; k < 4; k++) begin
      dir = 1'($urandom); limit = 8'($urandom);
      step();
      n_chk++;
      if (cnt_w !== 8'd3 || cnt_s !== 8'd3 || wrap_w || sat_s) begin
        n_fail++;
        $display("FAIL hold cycle %0d: counts=%0d/%0d, required 3 with no flag", k, cnt_w, cnt_s);
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    limit = 8'd12;
    for (int k = 0; k < 400; k++) begin
      clr = ($urandom_range(0, 29) == 0);
      load = ($urandom_range(0, 14) == 0);
      load_val = 8'($urandom_range(0, 40));
      en = ($urandom_range(0, 3) != 0);
      dir = 1'($urandom);
      if ($urandom_range(0, 19) == 0) limit = 8'($urandom_range(0, 30));
      step();
      for (int m = 0; m < 2; m++) begin
        logic [7:0] c;
        logic w, s, mx, mn;
        c  = (m == 0) ? cnt_w  : cnt_s;
        w  = (m == 0) ? wrap_w : wrap_s;
        s  = (m == 0) ? sat_w  : sat_s;
        mx = (m == 0) ? max_w  : max_s;
        mn = (m == 0) ? min_w  : min_s;
        n_chk++;
        if (c !== m_cnt[m] || w !== m_wrap[m] || s !== m_sat[m] ||
            mx !== (m_cnt[m] >= limit) || mn !== (m_cnt[m] == 8'd0)) begin
          n_fail++;
          $display("FAIL random inst%0d cyc %0d: cnt=%0d w=%b s=%b max=%b min=%b, required %0d %b %b %b %b",
                   m, k, c, w, s, mx, mn, m_cnt[m], m_wrap[m], m_sat[m],
                   (m_cnt[m] >= limit), (m_cnt[m] == 8'd0));
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    nrst = 1'b1;
    idle_inputs();
    limit = 8'd9;
    #2;
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_priority();
    test_limit_lower();
    test_async_reset();
    test_limit_zero();
    test_full_range();
    test_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/updown_mod_counter.md
UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter and limit width in bits (legal 2..32).
REQ-002 SHALL have parameter SATURATE, default 0; 0 selects wrap at the boundaries, 1 selects hold at the boundaries.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clr  input  1  synchronous clear to 0.
REQ-006 SHALL have port load  input  1  synchronous load of load_val.
REQ-007 SHALL have port load_val  input  WIDTH  value to load.
REQ-008 SHALL have port en  input  1  count enable, one step per enabled cycle.
REQ-009 SHALL have port dir  input  1  direction; 1 counts up, 0 counts down.
REQ-010 SHALL have port limit  input  WIDTH  inclusive upper bound; the count range is 0..limit.
REQ-011 SHALL have port count  output  WIDTH  registered count value.
REQ-012 SHALL have port wrapped  output  1  registered one-cycle pulse on a boundary crossing in wrap mode.
REQ-013 SHALL have port sat_hit  output  1  registered one-cycle pulse on a boundary step attempt in saturate mode.
REQ-014 SHALL have port at_max  output  1  combinational; high when count >= limit.
REQ-015 SHALL have port at_min  output  1  combinational; high when count == 0.

Function
REQ-016 SHALL give control priority per clock edge as clr > load > en; with none of them asserted, count holds.
REQ-017 SHALL, on clr, set count = 0, wrapped = 0 and sat_hit = 0.
REQ-018 SHALL, on load, set count = min(load_val, limit), wrapped = 0 and sat_hit = 0.
REQ-019 SHALL, on en with dir=1 and count < limit, set count = count + 1.
REQ-020 SHALL, on en with dir=1 and count >= limit, set count = 0 and wrapped = 1 when SATURATE=0.
REQ-021 SHALL, in the same up-boundary case with SATURATE=1, set count = limit and sat_hit = 1.
REQ-022 SHALL, on en with dir=0, count > 0 and count <= limit, set count = count - 1.
REQ-023 SHALL, on en with dir=0 and count == 0, set count = limit and wrapped = 1 when SATURATE=0.
REQ-024 SHALL, in the same down-boundary case with SATURATE=1, hold count = 0 and set sat_hit = 1.
REQ-025 SHALL, on en with dir=0 and count > limit (limit lowered mid-count), set count = limit and pulse no flag.
REQ-026 SHALL, on any cycle not described by REQ-020, REQ-021, REQ-023 or REQ-024, drive wrapped and sat_hit to 0; each flag is a single-cycle pulse per event.
REQ-027 SHALL update count, wrapped and sat_hit with 1-cycle latency from the sampled inputs.
REQ-028 SHALL produce the update on the same edge in which the inputs are sampled.
REQ-029 SHALL, with limit = 0, keep count at 0 on every enabled step.
REQ-030 SHALL, with limit = 0, also pulse wrapped (SATURATE=0) or sat_hit (SATURATE=1) on every enabled step.
REQ-031 SHALL perform all arithmetic in WIDTH bits; the value limit = 2^WIDTH-1 reproduces a plain free-running modulo-2^WIDTH counter.
REQ-032 SHALL ignore dir and limit changes when en, load and clr are all low.

Reset
REQ-033 SHALL, while nrst = 0, force count = 0, wrapped = 0 and sat_hit = 0 immediately, independent of clk.
REQ-034 SHALL resume counting on the first rising clk edge after nrst deasserts.
REQ-035 SHALL let an nrst assertion mid-count discard the in-progress step with no flag pulse.

Verification
REQ-036 SHALL cover: WIDTH=8, SATURATE=0, limit=9, en=1, dir=1 from reset -> count 0..9, then 0 with wrapped high for exactly 1 cycle; at_max high while count=9.
REQ-037 SHALL cover: SATURATE=0, limit=9, dir=0 from count=0 -> count=9 with wrapped pulse, then 8, 7.
REQ-038 SHALL cover: SATURATE=1, limit=5, dir=1 at count=5 for 3 cycles -> count stays 5 and sat_hit pulses each cycle; dir=0 at 0 -> count stays 0 and sat_hit pulses.
REQ-039 SHALL cover: clr=1, load=1, en=1 asserted together at count=4 -> count=0; then load=1 with load_val=200, limit=50 -> count=50.
REQ-040 SHALL cover: count=40, limit lowered to 20, dir=0 -> count=20 with no flag; the same lowering with dir=1 in wrap mode -> count=0 and wrapped=1.
REQ-041 SHALL cover: nrst pulsed low between clock edges at count=7 -> count=0 at once; counting restarts at 1 on the first edge after release.
